// File: rtl/fma_seq_norm_pkg.sv
// Shared definitions for the sequential FMA post-add normalizer.
//   cvw_t            : trimmed global FP configuration (only NF/NE are used here)
//   CVW_RV64D        : default configuration, double precision (NF=52, NE=11)
//   fmanorm_state_t  : normalizer FSM state encoding
//   ceil_div         : integer ceiling division used for the iteration limit
package fma_seq_norm_pkg;

  typedef struct packed {
    int NF;
    int NE;
  } cvw_t;

  localparam cvw_t CVW_RV64D = '{NF: 52, NE: 11};

  typedef enum logic [1:0] {FN_IDLE, FN_SHIFT, FN_DONE} fmanorm_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/fma_norm_step.sv
// One normalization step, purely combinational.
//   m, e    : current mantissa (W bits) and signed biased exponent (EW bits)
//   k       : left-shift amount applied this step (0..SHIFTSTEP)
//   m_next  : m << k, zero filled
//   e_next  : e - k
//   msb_set : m already normalized (leading one in the MSB)
//   clamp   : e <= 1 (signed); no further shifting allowed
module fma_norm_step #(
  parameter  int W         = 160,
  parameter  int EW        = 13,
  parameter  int SHIFTSTEP = 4,
  localparam int KW        = $clog2(SHIFTSTEP + 1)
) (
  input  logic [W-1:0]  m,
  input  logic [EW-1:0] e,
  output logic [KW-1:0] k,
  output logic [W-1:0]  m_next,
  output logic [EW-1:0] e_next,
  output logic          msb_set,
  output logic          clamp
);

  logic [KW-1:0] lz;
  logic [EW-1:0] em1;

  always_comb begin
    // Leading zeros of the top SHIFTSTEP bits; scanning upward leaves the
    // smallest index, i.e. the topmost one.
    lz = KW'(SHIFTSTEP);
    for (int i = SHIFTSTEP - 1; i >= 0; i--) begin
      if (m[W-1-i]) lz = KW'(i);
    end

    msb_set = m[W-1];
    clamp   = $signed(e) <= $signed(EW'(1));
    em1     = e - EW'(1);

    // Never shift the exponent below 1; when not clamped em1 >= 1 so an
    // unsigned compare is safe.
    k = lz;
    if (clamp)
      k = '0;
    else if (em1 < EW'(lz))
      k = KW'(em1);

    m_next = m << k;
    e_next = e - EW'(k);
  end

endmodule

// File: rtl/fma_seq_norm.sv
// Sequential post-add normalizer feeding the FMA rounder.
// Takes a positive sum mantissa Sm, exponent Se and sign Ss, left-shifts the
// mantissa up to SHIFTSTEP bits per cycle until the leading one reaches the
// MSB, the exponent reaches 1, or ceil(W/SHIFTSTEP) steps have been taken.
//   clk, reset             : clock, synchronous active-high reset
//   InValid/InReady        : operand handshake (InReady high only when idle)
//   Sm, Se, Ss             : sum mantissa (W), exponent (NE+2, signed), sign
//   OutValid/OutReady      : result handshake
//   NormM, NormE, NormS    : normalized mantissa, adjusted exponent, sign
//   Zero, Subnormal        : NormM==0; stopped by the exponent clamp unnormalized
// Optional feature: define FMA_NORM_ZERODET_EN to detect Sm==0 at accept and
// skip the shift loop entirely (result valid one cycle after accept).
module fma_seq_norm
  import fma_seq_norm_pkg::*;
#(
  parameter  cvw_t P         = CVW_RV64D,
  parameter  int   SHIFTSTEP = 4,
  localparam int   W         = 3 * P.NF + 4,
  localparam int   EW        = P.NE + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          InValid,
  output logic          InReady,
  input  logic [W-1:0]  Sm,
  input  logic [EW-1:0] Se,
  input  logic          Ss,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [W-1:0]  NormM,
  output logic [EW-1:0] NormE,
  output logic          NormS,
  output logic          Zero,
  output logic          Subnormal
);

  localparam int CNT_MAX = ceil_div(W, SHIFTSTEP);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int KW      = $clog2(SHIFTSTEP + 1);

  fmanorm_state_t state_q, state_d;
  logic [W-1:0]   m_q, m_d;
  logic [EW-1:0]  e_q, e_d;
  logic           s_q, s_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sub_q, sub_d;
  logic           zero_q, zero_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  logic [KW-1:0]  step_k;
  logic [W-1:0]   step_m;
  logic [EW-1:0]  step_e;
  logic           step_msb, step_clamp;
  logic           unused_k;

  fma_norm_step #(.W(W), .EW(EW), .SHIFTSTEP(SHIFTSTEP)) u_step (
    .m       (m_q),
    .e       (e_q),
    .k       (step_k),
    .m_next  (step_m),
    .e_next  (step_e),
    .msb_set (step_msb),
    .clamp   (step_clamp)
  );

  // The shift amount is already folded into step_m/step_e.
  assign unused_k = |step_k;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    zero_d  = zero_q;

    unique case (state_q)
      FN_IDLE: begin
        // InReady is high throughout IDLE, so InValid alone is the handshake.
        if (InValid) begin
          m_d     = Sm;
          e_d     = Se;
          s_d     = Ss;
          cnt_d   = '0;
          sub_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = FN_SHIFT;
`ifdef FMA_NORM_ZERODET_EN
          if (Sm == '0) begin
            zero_d  = 1'b1;
            state_d = FN_DONE;
          end
`endif
        end
      end
      FN_SHIFT: begin
        if (step_msb) begin
          state_d = FN_DONE;
        end else if (step_clamp) begin
          sub_d   = 1'b1;
          state_d = FN_DONE;
        end else if (cnt_q == CW'(CNT_MAX)) begin
          state_d = FN_DONE;
        end else begin
          m_d   = step_m;
          e_d   = step_e;
          cnt_d = cnt_q + CW'(1);
        end
        // M is not modified on the exit cycle, so its current value is final.
        if (state_d == FN_DONE) zero_d = (m_q == '0);
      end
      FN_DONE: begin
        if (OutReady) state_d = FN_IDLE;
      end
      default: state_d = FN_IDLE;
    endcase

    in_ready_d  = (state_d == FN_IDLE);
    out_valid_d = (state_d == FN_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FN_IDLE;
      m_q         <= '0;
      e_q         <= '0;
      s_q         <= 1'b0;
      cnt_q       <= '0;
      sub_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      e_q         <= e_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign InReady   = in_ready_q;
  assign OutValid  = out_valid_q;
  assign NormM     = m_q;
  assign NormE     = e_q;
  assign NormS     = s_q;
  assign Zero      = zero_q;
  assign Subnormal = sub_q;

endmodule

// File: tb/tb_fma_seq_norm.sv
// Bench for fma_seq_norm (default RV64 D configuration, W=160, SHIFTSTEP=4).
// Directed cases plus randomized operands, checked against a closed-form
// model: total shift = min(lz, Se-1, W), latency = 2 + ceil(shift/4).
module tb_fma_seq_norm;

  localparam int W  = 160;
  localparam int EW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          InValid, InReady;
  logic [W-1:0]  Sm;
  logic [EW-1:0] Se;
  logic          Ss;
  logic          OutValid, OutReady;
  logic [W-1:0]  NormM;
  logic [EW-1:0] NormE;
  logic          NormS, Zero, Subnormal;

  int total = 0;
  int bad   = 0;

  fma_seq_norm dut (
    .clk       (clk),
    .reset     (reset),
    .InValid   (InValid),
    .InReady   (InReady),
    .Sm        (Sm),
    .Se        (Se),
    .Ss        (Ss),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .NormM     (NormM),
    .NormE     (NormE),
    .NormS     (NormS),
    .Zero      (Zero),
    .Subnormal (Subnormal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: outcome of normalizing sm/se by the block's stopping rules.
  task automatic model(input logic [W-1:0] sm, input int se,
                       output logic [W-1:0] m, output int e,
                       output bit z, output bit sub, output int lat);
    int lz, cap, t;
`ifdef FMA_NORM_ZERODET_EN
    if (sm == '0) begin
      m = '0; e = se; z = 1'b1; sub = 1'b0; lat = 1;
      return;
    end
`endif
    lz = W;
    for (int i = 0; i < W; i++) if (sm[i]) lz = W - 1 - i;
    cap = (se > 1) ? se - 1 : 0;
    t = lz;
    if (cap < t) t = cap;
    if (W < t) t = W;
    m   = sm << t;
    e   = se - t;
    z   = (m == '0);
    sub = !m[W-1] && (e <= 1);
    lat = 2 + (t + 3) / 4;
  endtask

  task automatic run(input string tag, input logic [W-1:0] sm, input int se,
                     input logic ss, input int stall);
    logic [W-1:0]  xm;
    logic [EW-1:0] xe;
    int            e_i, lat, cyc;
    bit            z, sub, found;
    model(sm, se, xm, e_i, z, sub, lat);
    xe = EW'(e_i);

    @(negedge clk);
    chk({tag, ".inready_idle"}, W'(InReady), W'(1'b1));
    InValid  = 1'b1;
    Sm       = sm;
    Se       = EW'(se);
    Ss       = ss;
    OutReady = (stall == 0);
    @(posedge clk);  // accept, cycle 0

    cyc   = 0;
    found = 1'b0;
    while (cyc < 80) begin
      @(negedge clk);
      cyc++;
      // A second operand offered while busy must be ignored.
      if (cyc == 1 && lat > 1) begin
        InValid = 1'b1; Sm = ~sm; Se = EW'(7); Ss = ~ss;
      end else begin
        InValid = 1'b0;
      end
      if (OutValid) begin
        found = 1'b1;
        break;
      end
    end
    InValid = 1'b0;
    chk({tag, ".latency"}, W'(cyc), W'(lat));
    if (!found) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      OutReady = 1'b1;
      return;
    end
    chk({tag, ".m"},     NormM,         xm);
    chk({tag, ".e"},     W'(NormE),     W'(xe));
    chk({tag, ".s"},     W'(NormS),     W'(ss));
    chk({tag, ".zero"},  W'(Zero),      W'(z));
    chk({tag, ".sub"},   W'(Subnormal), W'(sub));
    chk({tag, ".busy"},  W'(InReady),   W'(1'b0));

    for (int s = 1; s < stall; s++) begin
      @(negedge clk);
      chk({tag, ".hold_v"}, W'(OutValid), W'(1'b1));
      chk({tag, ".hold_m"}, NormM,        xm);
      chk({tag, ".hold_e"}, W'(NormE),    W'(xe));
      chk({tag, ".hold_f"}, W'({Zero, Subnormal}), W'({z, sub}));
      chk({tag, ".hold_r"}, W'(InReady),  W'(1'b0));
    end
    OutReady = 1'b1;
    @(negedge clk);
    chk({tag, ".post_v"}, W'(OutValid), W'(1'b0));
    chk({tag, ".post_r"}, W'(InReady),  W'(1'b1));
  endtask

  logic [W-1:0] one;
  logic [W-1:0] rnd;

  initial begin
    one      = W'(1);
    reset    = 1'b1;
    InValid  = 1'b0;
    Sm       = '0;
    Se       = '0;
    Ss       = 1'b0;
    OutReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst.inready",  W'(InReady),   W'(1'b1));
    chk("rst.outvalid", W'(OutValid),  W'(1'b0));
    chk("rst.m",        NormM,         '0);
    chk("rst.e",        W'(NormE),     '0);
    chk("rst.flags",    W'({NormS, Zero, Subnormal}), '0);
    reset = 1'b0;

    run("t1_msb",      one << 159, 1023, 1'b1, 0);
    run("t2_lz10",     one << 149, 1023, 1'b0, 0);
    run("t3_clamp",    one << 149, 3,    1'b1, 0);
    run("t4_zero500",  '0,         500,  1'b0, 0);
    run("t4_zero9",    '0,         9,    1'b1, 0);
    run("t5_stall",    one << 149, 1023, 1'b0, 3);
    run("msb_e0",      one << 159, 0,    1'b0, 0);
    run("lz159",       one,        1023, 1'b1, 0);
    run("neg_e",       W'(5),      -3,   1'b0, 0);
    run("e_eq_lz",     one << 149, 11,   1'b1, 0);

    // Reset during operation discards the operand.
    @(negedge clk);
    InValid = 1'b1; Sm = one << 149; Se = EW'(1023); Ss = 1'b1;
    @(posedge clk);           // accept, cycle 0
    @(negedge clk);           // cycle 1
    InValid = 1'b0;
    @(negedge clk);           // cycle 2
    @(negedge clk);           // cycle 3
    reset = 1'b1;
    @(negedge clk);           // cycle 4
    chk("t6.outvalid", W'(OutValid), W'(1'b0));
    chk("t6.inready",  W'(InReady),  W'(1'b1));
    chk("t6.m",        NormM,        '0);
    reset = 1'b0;
    run("t6_after",    one << 149, 1023, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rnd = rnd >> $urandom_range(0, 165);
      run($sformatf("rnd%0d", n), rnd, int'($urandom_range(0, 400)) - 100,
          1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
